// File: rtl/wb_dbg_master_pkg.sv
// Shared definitions for the byte-stream Wishbone debug master:
// command/response codes and the FSM state encoding.
package wb_dbg_master_pkg;

   localparam logic [7:0] CMD_WRITE = 8'h01;
   localparam logic [7:0] CMD_READ  = 8'h02;

   localparam logic [7:0] RSP_OK  = 8'hA5;
   localparam logic [7:0] RSP_ERR = 8'hEE;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_BUS,
      ST_RESP
   } state_t;

   // True for the two opcodes that start a command; everything else is noise.
   function automatic logic is_cmd(input logic [7:0] b);
      return (b == CMD_WRITE) || (b == CMD_READ);
   endfunction

endpackage

// File: rtl/wb_dbg_master_if.sv
// Single-master Wishbone classic bus bundle; signal names keep the
// _o/_i suffixes as seen from the debug master.
interface wb_dbg_master_if;

   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_ack_i;
   logic        wb_err_i;
   logic        wb_rty_i;

   modport master (
      output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
      input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
   );

   modport slave (
      input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
      output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
   );

endinterface

// File: rtl/wb_dbg_resp_tx.sv
// Response serialiser: takes 1 or 4 bytes (MSB first) and pushes them to
// the UART transmitter, never strobing while it is busy and never on two
// consecutive cycles so the transmitter always sees tx_busy rise in between.
module wb_dbg_resp_tx (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        load,
   input  logic [31:0] load_data,
   input  logic [2:0]  load_count,
   input  logic        tx_busy,
   output logic [7:0]  tx_data,
   output logic        tx_wr,
   output logic        done
);

   logic [31:0] sh_q, sh_d;
   logic [2:0]  rem_q, rem_d;
   logic        wr_prev_q, wr_prev_d;

   // The strobe is decoded from the current tx_busy so it is never issued
   // into a transmitter that is already busy in that same cycle.
   assign tx_wr   = (rem_q != 3'd0) && !tx_busy && !wr_prev_q;
   assign tx_data = sh_q[31:24];
   assign done    = (rem_q == 3'd0);

   // Next-state for the shift register and remaining-byte count.
   always_comb begin
      sh_d      = sh_q;
      rem_d     = rem_q;
      wr_prev_d = tx_wr;
      if (load) begin
         sh_d  = load_data;
         rem_d = load_count;
      end else if (tx_wr) begin
         sh_d  = {sh_q[23:0], 8'h00};
         rem_d = rem_q - 3'd1;
      end
   end

   // State registers, cleared by the synchronous reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sh_q      <= '0;
         rem_q     <= '0;
         wr_prev_q <= 1'b0;
      end else begin
         sh_q      <= sh_d;
         rem_q     <= rem_d;
         wr_prev_q <= wr_prev_d;
      end
   end

endmodule

// File: rtl/wb_dbg_master.sv
// Host debug port: parses write/read commands from the UART byte stream,
// runs one Wishbone cycle per command and returns a status or data reply.
module wb_dbg_master
   import wb_dbg_master_pkg::*;
#(
   parameter int unsigned bus_timeout = 1024,
   parameter int unsigned rx_timeout  = 5000000
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [7:0]             rx_data,
   input  logic                   rx_valid,
   output logic [7:0]             tx_data,
   output logic                   tx_wr,
   input  logic                   tx_busy,
   output logic                   busy,
   wb_dbg_master_if.master        wb
);

   localparam int RXW = (rx_timeout  > 1) ? $clog2(rx_timeout)  : 1;
   localparam int BSW = (bus_timeout > 1) ? $clog2(bus_timeout) : 1;
   localparam logic [RXW-1:0] RX_LAST  = RXW'(rx_timeout - 1);
   localparam logic [BSW-1:0] BUS_LAST = BSW'(bus_timeout - 1);

   state_t          state_q, state_d;
   logic            is_write_q, is_write_d;
   logic [1:0]      byte_cnt_q, byte_cnt_d;
   logic [31:0]     adr_q, adr_d;
   logic [31:0]     dat_q, dat_d;
   logic            cyc_q, cyc_d;
   logic            stb_q, stb_d;
   logic            we_q, we_d;
   logic            busy_q, busy_d;
   logic [RXW-1:0]  rx_cnt_q, rx_cnt_d;
   logic [BSW-1:0]  bus_cnt_q, bus_cnt_d;

   logic            rsp_load;
   logic [31:0]     rsp_data;
   logic [2:0]      rsp_count;
   logic            rsp_done;

   assign wb.wb_adr_o = adr_q;
   assign wb.wb_dat_o = dat_q;
   assign wb.wb_sel_o = 4'hF;
   assign wb.wb_we_o  = we_q;
   assign wb.wb_cyc_o = cyc_q;
   assign wb.wb_stb_o = stb_q;
   assign busy        = busy_q;

   // Command parser and Wishbone cycle control; bus outputs change only on
   // state transitions so they come straight from flops.
   always_comb begin
      state_d    = state_q;
      is_write_d = is_write_q;
      byte_cnt_d = byte_cnt_q;
      adr_d      = adr_q;
      dat_d      = dat_q;
      cyc_d      = cyc_q;
      stb_d      = stb_q;
      we_d       = we_q;
      rx_cnt_d   = rx_cnt_q;
      bus_cnt_d  = bus_cnt_q;
      rsp_load   = 1'b0;
      rsp_data   = '0;
      rsp_count  = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (rx_valid && is_cmd(rx_data)) begin
               is_write_d = (rx_data == CMD_WRITE);
               byte_cnt_d = '0;
               rx_cnt_d   = '0;
               state_d    = ST_ADDR;
            end
         end
         ST_ADDR, ST_DATA: begin
            if (rx_valid) begin
               rx_cnt_d   = '0;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (state_q == ST_ADDR) begin
                  adr_d = {adr_q[23:0], rx_data};
               end else begin
                  dat_d = {dat_q[23:0], rx_data};
               end
               if (byte_cnt_q == 2'd3) begin
                  if ((state_q == ST_ADDR) && is_write_q) begin
                     state_d = ST_DATA;
                  end else begin
                     state_d   = ST_BUS;
                     cyc_d     = 1'b1;
                     stb_d     = 1'b1;
                     we_d      = is_write_q;
                     bus_cnt_d = '0;
                  end
               end
            end else if (rx_cnt_q == RX_LAST) begin
               state_d = ST_IDLE;
            end else begin
               rx_cnt_d = rx_cnt_q + RXW'(1);
            end
         end
         ST_BUS: begin
            if (wb.wb_ack_i || wb.wb_err_i || wb.wb_rty_i) begin
               cyc_d    = 1'b0;
               stb_d    = 1'b0;
               we_d     = 1'b0;
               state_d  = ST_RESP;
               rsp_load = 1'b1;
               if (wb.wb_err_i || wb.wb_rty_i) begin
                  rsp_data  = {RSP_ERR, 24'h0};
                  rsp_count = 3'd1;
               end else if (is_write_q) begin
                  rsp_data  = {RSP_OK, 24'h0};
                  rsp_count = 3'd1;
               end else begin
                  rsp_data  = wb.wb_dat_i;
                  rsp_count = 3'd4;
               end
            end else if (bus_cnt_q == BUS_LAST) begin
               cyc_d     = 1'b0;
               stb_d     = 1'b0;
               we_d      = 1'b0;
               state_d   = ST_RESP;
               rsp_load  = 1'b1;
               rsp_data  = {RSP_ERR, 24'h0};
               rsp_count = 3'd1;
            end else begin
               bus_cnt_d = bus_cnt_q + BSW'(1);
            end
         end
         ST_RESP: begin
            if (rsp_done) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d == ST_BUS) || (state_d == ST_RESP);
   end

   // Register bank for the parser/bus FSM.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         is_write_q <= 1'b0;
         byte_cnt_q <= '0;
         adr_q      <= '0;
         dat_q      <= '0;
         cyc_q      <= 1'b0;
         stb_q      <= 1'b0;
         we_q       <= 1'b0;
         busy_q     <= 1'b0;
         rx_cnt_q   <= '0;
         bus_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         is_write_q <= is_write_d;
         byte_cnt_q <= byte_cnt_d;
         adr_q      <= adr_d;
         dat_q      <= dat_d;
         cyc_q      <= cyc_d;
         stb_q      <= stb_d;
         we_q       <= we_d;
         busy_q     <= busy_d;
         rx_cnt_q   <= rx_cnt_d;
         bus_cnt_q  <= bus_cnt_d;
      end
   end

   wb_dbg_resp_tx u_resp_tx (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (rsp_load),
      .load_data  (rsp_data),
      .load_count (rsp_count),
      .tx_busy    (tx_busy),
      .tx_data    (tx_data),
      .tx_wr      (tx_wr),
      .done       (rsp_done)
   );

endmodule

// File: tb/tb_wb_dbg_master.sv
// Directed bench for wb_dbg_master: a Wishbone slave model, a UART
// transmitter busy model and monitors feed checks made from one initial block.
module tb_wb_dbg_master;

   localparam int SLV_ACK    = 0;
   localparam int SLV_ERRACK = 1;
   localparam int SLV_RTY    = 2;
   localparam int SLV_NONE   = 3;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_wr;
   logic       tx_busy;
   logic       busy;

   wb_dbg_master_if wb_bus ();

   wb_dbg_master #(
      .bus_timeout (16),
      .rx_timeout  (100)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_wr    (tx_wr),
      .tx_busy  (tx_busy),
      .busy     (busy),
      .wb       (wb_bus.master)
   );

   always #5 clk = ~clk;

   int checks    = 0;
   int passes    = 0;
   int slave_mode  = SLV_ACK;
   int wait_target = 0;
   int wait_cnt    = 0;
   int busy_cnt    = 0;
   logic last_wr   = 1'b0;
   int tx_viol     = 0;
   int bus_viol    = 0;
   int bus_starts  = 0;
   int cur_len     = 0;
   int last_len    = 0;
   logic [31:0] cap_adr = '0;
   logic [31:0] cap_dat = '0;
   logic        cap_we  = 1'b0;
   logic [3:0]  cap_sel = '0;
   logic [7:0]  tx_q[$];

   // Wishbone slave: acks after wait_target cycles, or errors/retries/hangs.
   always @(posedge clk) begin
      #1;
      if (wb_bus.wb_cyc_o && wb_bus.wb_stb_o) begin
         case (slave_mode)
            SLV_ACK: begin
               if (wait_cnt == wait_target) begin
                  wb_bus.wb_ack_i = 1'b1;
                  wb_bus.wb_dat_i = 32'h12345678;
               end else begin
                  wb_bus.wb_ack_i = 1'b0;
                  wait_cnt++;
               end
            end
            SLV_ERRACK: begin
               wb_bus.wb_ack_i = 1'b1;
               wb_bus.wb_err_i = 1'b1;
               wb_bus.wb_dat_i = 32'h12345678;
            end
            SLV_RTY: wb_bus.wb_rty_i = 1'b1;
            default: ;
         endcase
      end else begin
         wb_bus.wb_ack_i = 1'b0;
         wb_bus.wb_err_i = 1'b0;
         wb_bus.wb_rty_i = 1'b0;
         wb_bus.wb_dat_i = 32'h0;
         wait_cnt = 0;
      end
   end

   // UART transmitter model: busy for three cycles after every strobe.
   always @(posedge clk) begin
      #1;
      if (last_wr) busy_cnt = 3;
      else if (busy_cnt > 0) busy_cnt--;
      tx_busy = (busy_cnt != 0);
   end

   // Monitors for response bytes and Wishbone cycles.
   always @(negedge clk) begin
      if (tx_wr) begin
         tx_q.push_back(tx_data);
         if (tx_busy || last_wr) tx_viol++;
      end
      last_wr = tx_wr;
      if (wb_bus.wb_cyc_o) begin
         if (cur_len == 0) begin
            bus_starts++;
            cap_adr = wb_bus.wb_adr_o;
            cap_dat = wb_bus.wb_dat_o;
            cap_we  = wb_bus.wb_we_o;
            cap_sel = wb_bus.wb_sel_o;
         end
         cur_len++;
         if (!busy) bus_viol++;
      end else if (cur_len != 0) begin
         last_len = cur_len;
         cur_len  = 0;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) passes++;
      else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      @(posedge clk);
      #1;
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic clearStats();
      tx_q.delete();
      bus_starts = 0;
      last_len   = 0;
   endtask

   task automatic waitResp(input string tag, input int n, input int budget);
      logic ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(posedge clk);
         #1;
         if (tx_q.size() >= n && !busy) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput(tag, {31'h0, ok}, 32'h1);
   endtask

   function automatic logic [7:0] qbyte(input int i);
      if (i < tx_q.size()) return tx_q[i];
      return 8'hxx;
   endfunction

   initial begin
      reset_n  = 1'b0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      tx_busy  = 1'b0;
      wb_bus.wb_ack_i = 1'b0;
      wb_bus.wb_err_i = 1'b0;
      wb_bus.wb_rty_i = 1'b0;
      wb_bus.wb_dat_i = 32'h0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_cyc",  {31'h0, wb_bus.wb_cyc_o}, 32'h0);
      checkOutput("rst_stb",  {31'h0, wb_bus.wb_stb_o}, 32'h0);
      checkOutput("rst_we",   {31'h0, wb_bus.wb_we_o},  32'h0);
      checkOutput("rst_txwr", {31'h0, tx_wr},           32'h0);
      checkOutput("rst_busy", {31'h0, busy},            32'h0);
      checkOutput("rst_adr",  wb_bus.wb_adr_o,          32'h0);
      checkOutput("rst_dat",  wb_bus.wb_dat_o,          32'h0);
      checkOutput("rst_txd",  {24'h0, tx_data},         32'h0);
      reset_n = 1'b1;
      repeat (2) @(posedge clk);

      // Write with a two-wait-state slave
      $display("[TB] write 0x10 <- DEADBEEF");
      clearStats();
      slave_mode = SLV_ACK; wait_target = 2;
      applyStimulus(8'h01);
      applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h10);
      applyStimulus(8'hDE); applyStimulus(8'hAD); applyStimulus(8'hBE); applyStimulus(8'hEF);
      waitResp("wr_done", 1, 100);
      checkOutput("wr_starts", bus_starts, 32'd1);
      checkOutput("wr_adr",    cap_adr, 32'h00000010);
      checkOutput("wr_dat",    cap_dat, 32'hDEADBEEF);
      checkOutput("wr_we",     {31'h0, cap_we},  32'h1);
      checkOutput("wr_sel",    {28'h0, cap_sel}, 32'hF);
      checkOutput("wr_len",    last_len, 32'd3);
      checkOutput("wr_ntx",    tx_q.size(), 32'd1);
      checkOutput("wr_rsp",    {24'h0, qbyte(0)}, 32'hA5);

      // Read with a zero-wait slave and a busy transmitter
      $display("[TB] read 0xF0000004");
      clearStats();
      slave_mode = SLV_ACK; wait_target = 0;
      applyStimulus(8'h02);
      applyStimulus(8'hF0); applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h04);
      waitResp("rd_done", 4, 100);
      checkOutput("rd_starts", bus_starts, 32'd1);
      checkOutput("rd_adr",    cap_adr, 32'hF0000004);
      checkOutput("rd_we",     {31'h0, cap_we}, 32'h0);
      checkOutput("rd_len",    last_len, 32'd1);
      checkOutput("rd_ntx",    tx_q.size(), 32'd4);
      checkOutput("rd_b0",     {24'h0, qbyte(0)}, 32'h12);
      checkOutput("rd_b1",     {24'h0, qbyte(1)}, 32'h34);
      checkOutput("rd_b2",     {24'h0, qbyte(2)}, 32'h56);
      checkOutput("rd_b3",     {24'h0, qbyte(3)}, 32'h78);

      // err together with ack wins
      clearStats();
      slave_mode = SLV_ERRACK;
      applyStimulus(8'h02);
      applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h08);
      waitResp("err_done", 1, 100);
      repeat (10) @(posedge clk);
      #1;
      checkOutput("err_ntx", tx_q.size(), 32'd1);
      checkOutput("err_rsp", {24'h0, qbyte(0)}, 32'hEE);

      // rty alone is also a failure
      clearStats();
      slave_mode = SLV_RTY;
      applyStimulus(8'h02);
      applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h0C);
      waitResp("rty_done", 1, 100);
      repeat (10) @(posedge clk);
      #1;
      checkOutput("rty_ntx", tx_q.size(), 32'd1);
      checkOutput("rty_rsp", {24'h0, qbyte(0)}, 32'hEE);

      // Silent slave: abort after 16 cycles, then a normal read
      clearStats();
      slave_mode = SLV_NONE;
      applyStimulus(8'h02);
      applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h01); applyStimulus(8'h00);
      waitResp("tmo_done", 1, 200);
      checkOutput("tmo_len", last_len, 32'd16);
      checkOutput("tmo_rsp", {24'h0, qbyte(0)}, 32'hEE);
      clearStats();
      slave_mode = SLV_ACK; wait_target = 0;
      applyStimulus(8'h02);
      applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h01); applyStimulus(8'h04);
      waitResp("tmo_next_done", 4, 100);
      checkOutput("tmo_next_adr", cap_adr, 32'h00000104);
      checkOutput("tmo_next_b0",  {24'h0, qbyte(0)}, 32'h12);
      checkOutput("tmo_next_b3",  {24'h0, qbyte(3)}, 32'h78);

      // Framing: junk byte ignored, slow-but-in-time bytes accepted
      clearStats();
      applyStimulus(8'h7F);
      applyStimulus(8'h02);
      applyStimulus(8'h00);
      repeat (50) @(posedge clk);
      applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h04);
      waitResp("frm_done", 4, 100);
      checkOutput("frm_adr", cap_adr, 32'h00000004);
      checkOutput("frm_b1",  {24'h0, qbyte(1)}, 32'h34);

      // Framing: stalled partial command is dropped without any reply
      clearStats();
      applyStimulus(8'h02);
      applyStimulus(8'h00);
      repeat (120) @(posedge clk);
      #1;
      checkOutput("rxt_ntx",  tx_q.size(), 32'd0);
      checkOutput("rxt_busy", {31'h0, busy}, 32'h0);
      slave_mode = SLV_ACK; wait_target = 2;
      applyStimulus(8'h01);
      applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h20);
      applyStimulus(8'hCA); applyStimulus(8'hFE); applyStimulus(8'hBA); applyStimulus(8'hBE);
      waitResp("rxt_wr_done", 1, 100);
      checkOutput("rxt_wr_adr", cap_adr, 32'h00000020);
      checkOutput("rxt_wr_dat", cap_dat, 32'hCAFEBABE);
      checkOutput("rxt_wr_rsp", {24'h0, qbyte(0)}, 32'hA5);

      // Reset while a cycle is outstanding
      clearStats();
      slave_mode = SLV_NONE;
      applyStimulus(8'h02);
      applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h08);
      for (int k = 0; k < 20; k++) begin
         if (wb_bus.wb_cyc_o) break;
         @(posedge clk);
         #1;
      end
      checkOutput("mrst_cyc_before", {31'h0, wb_bus.wb_cyc_o}, 32'h1);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("mrst_cyc",  {31'h0, wb_bus.wb_cyc_o}, 32'h0);
      checkOutput("mrst_stb",  {31'h0, wb_bus.wb_stb_o}, 32'h0);
      checkOutput("mrst_we",   {31'h0, wb_bus.wb_we_o},  32'h0);
      checkOutput("mrst_busy", {31'h0, busy},            32'h0);
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      checkOutput("mrst_ntx", tx_q.size(), 32'd0);

      // Global protocol rules observed by the monitors
      checkOutput("tx_rule_viol",  tx_viol,  32'd0);
      checkOutput("bus_busy_viol", bus_viol, 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/wb_dbg_master.md
Name: wb_dbg_master

Overview:
- Wishbone bus initiator driven by a byte stream (UART RX/TX byte interface); turns host debug commands into single 32-bit Wishbone read/write cycles.
- Occupies a spare master port of the system interconnect, beside the LM32 instruction and data masters.
- Lets a host PC peek/poke BRAM, DDR, UART and timer registers without the CPU.

Parameters:
- bus_timeout, 1024, cycles allowed between stb assertion and ack/err/rty before the cycle is aborted.
- rx_timeout, 5000000, idle cycles allowed between bytes of a partial command before the partial command is discarded.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous reset, active low
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid; no backpressure
- tx_data  out  8  response byte
- tx_wr  out  1  one-cycle strobe, send tx_data
- tx_busy  in  1  transmitter busy; tx_wr only issued when low
- busy  out  1  high in BUS and RESP states
- wb_adr_o  out  32  bus address
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data
- wb_sel_o  out  4  byte select, constant 4'hF
- wb_we_o  out  1  write enable
- wb_cyc_o  out  1  cycle
- wb_stb_o  out  1  strobe
- wb_ack_i  in  1  acknowledge
- wb_err_i  in  1  error
- wb_rty_i  in  1  retry (treated as error)

Behaviour:
- Reset (reset_n low at a clk edge): state IDLE; cyc/stb/we/tx_wr/busy = 0; adr/dat_o/tx_data = 0; all counters cleared. Applies mid-cycle: cyc/stb drop on the next edge, no response byte is sent.
- Command format:
  - write: 0x01, A3 A2 A1 A0, D3 D2 D1 D0 (MSB first).
  - read: 0x02, A3..A0.
- Responses:
  - write OK: 0xA5.
  - read OK: D3 D2 D1 D0.
  - any failure: single byte 0xEE.
- IDLE: on rx_valid with 0x01 or 0x02, latch command and go to ADDR. Any other byte is ignored and the state stays IDLE.
- ADDR: shift each byte into adr from the LSB side (adr <= {adr[23:0], byte}). After the 4th byte, go to DATA for a write or BUS for a read.
- DATA: shift 4 bytes into wb_dat_o the same way, then go to BUS.
- Inter-byte timeout: in ADDR/DATA, the counter resets on each rx_valid. When it reaches rx_timeout, return to IDLE with no response.
- BUS:
  - On the entry edge assert cyc=stb=1 and we=(cmd==write).
  - The first cycle where ack|err|rty is high terminates: deassert cyc/stb/we on the next edge.
  - Latch wb_dat_i on ack for a read.
  - Status priority: err/rty over ack when several are high together.
  - If the bus counter reaches bus_timeout, drop cyc/stb; status = fail.
  - Minimum cycle length: 1 cycle for a zero-wait slave (cyc high exactly 1 cycle).
- RESP:
  - Emit 1 byte (write OK / fail) or 4 bytes (read OK).
  - Each tx_wr pulse is one cycle and occurs only in a cycle where tx_busy=0 and no tx_wr was issued in the previous cycle.
  - After the last byte, return to IDLE.
- Bytes arriving in BUS/RESP are discarded; the next command starts fresh from IDLE.
- No pipelining: at most one outstanding Wishbone cycle.

Decomposition:
- Shared package/include (wb_dbg_defs):
  - command codes CMD_WRITE=8'h01, CMD_READ=8'h02.
  - response codes RSP_OK=8'hA5, RSP_ERR=8'hEE.
  - state encoding IDLE/ADDR/DATA/BUS/RESP.
- One natural sub-module: wb_dbg_resp_tx. It loads 1 or 4 bytes plus a count, serialises them onto tx_data/tx_wr honoring tx_busy, and raises done.
- Command parsing and the Wishbone FSM stay in the top block.

Test Plan:
- Write: bytes 01 00 00 00 10 DE AD BE EF, slave acks 2 cycles after stb -> exactly one cycle with adr=0x00000010, dat_o=0xDEADBEEF, we=1, sel=F; then tx byte A5.
- Read: bytes 02 F0 00 00 04, slave returns 0x12345678 with zero-wait ack -> cyc high 1 cycle, we=0; tx bytes 12 34 56 78 in order with tx_busy toggling, no byte lost or duplicated.
- Error: read with err asserted together with ack -> tx single byte EE, no data bytes; rty-only gives the same result.
- Bus timeout: slave never responds, bus_timeout=16 -> cyc/stb drop after 16 cycles; tx EE; the next command executes normally.
- Framing:
  - bytes 7F 02 00 -> 7F ignored, partial read started.
  - with no further bytes for rx_timeout=100 cycles -> back to IDLE with no tx output, and the following 01 command is parsed correctly.
- Reset mid-cycle: reset_n low while cyc=1 -> next edge cyc/stb/we=0, tx_wr never pulses, busy=0.
